// File: rtl/lfsr_pkg.sv
// Shared constants, FSM state type and LFSR step function for the LFSR decrypt engine.
package lfsr_pkg;

   localparam logic [7:0]  SPACE    = 8'h20;
   localparam int unsigned NUM_TAPS = 8;

   // Candidate feedback taps, tried in index order; the lowest match wins.
   localparam logic [7:0] TAP_LUT [NUM_TAPS] = '{
      8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3
   };

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSearch,
      StSkip,
      StEmit,
      StDone
   } state_e;

   function automatic logic [7:0] lfsr_next(input logic [7:0] state, input logic [7:0] tap);
      return {state[6:0], ^(state & tap)};
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR advance, shared by the tap search and the skip/emit datapath.
module lfsr_step
   import lfsr_pkg::*;
(
   input  logic [7:0] state_i,
   input  logic [7:0] tap_i,
   output logic [7:0] next_o
);

   assign next_o = lfsr_next(state_i, tap_i);

endmodule

// File: rtl/lfsr_decrypt_engine.sv
// Decrypts one 64-byte LFSR ciphertext frame: recovers seed/tap from the space preamble,
// strips leading spaces and streams plaintext out. Optional key report: LFSR_KEY_REPORT_EN.
module lfsr_decrypt_engine
   import lfsr_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 64,
   parameter int unsigned PRE_CHECK = 9,
   parameter int unsigned MAX_OUT   = 41
) (
   input  logic       clk,
   input  logic       init,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic [5:0] out_count,
   output logic       done,
`ifdef LFSR_KEY_REPORT_EN
   output logic       err,
   output logic [2:0] key_tap_idx,
   output logic [7:0] key_seed
`else
   output logic       err
`endif
);

   localparam int unsigned     IdxW      = $clog2(FRAME_LEN);
   localparam logic [IdxW-1:0] LastIdx   = IdxW'(FRAME_LEN - 1);
   localparam logic [IdxW-1:0] LastPre   = IdxW'(PRE_CHECK - 1);
   localparam logic [IdxW-1:0] FirstK    = IdxW'(1);
   localparam logic [5:0]      LastOut   = 6'(MAX_OUT - 1);

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [IdxW-1:0] k_q, k_d;
   logic [2:0]      tap_idx_q, tap_idx_d;
   logic [7:0]      lfsr_q, lfsr_d;
   logic [5:0]      out_count_q, out_count_d;
   logic            err_q, err_d;
   logic            key_valid_q, key_valid_d;

   logic [7:0] frame_q [FRAME_LEN];

   logic [7:0] seed;
   logic [7:0] tap;
   logic [7:0] lfsr_adv;
   logic [7:0] cur_byte;
   logic [7:0] adv_plain;
   logic [7:0] emit_plain;
   logic       frame_we;

   assign seed       = frame_q[0] ^ SPACE;
   assign tap        = TAP_LUT[tap_idx_q];
   assign cur_byte   = frame_q[k_q];
   // In SEARCH/SKIP lfsr_q lags k by one step; in EMIT it already holds state_k.
   assign adv_plain  = cur_byte ^ lfsr_adv;
   assign emit_plain = cur_byte ^ lfsr_q;
   assign frame_we   = (state_q == StLoad) && in_valid;

   lfsr_step u_lfsr_step (
      .state_i (lfsr_q),
      .tap_i   (tap),
      .next_o  (lfsr_adv)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      k_d         = k_q;
      tap_idx_d   = tap_idx_q;
      lfsr_d      = lfsr_q;
      out_count_d = out_count_q;
      err_d       = err_q;
      key_valid_d = key_valid_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_data    = 8'h00;
      done        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StLoad;
               idx_d       = '0;
               err_d       = 1'b0;
               out_count_d = '0;
               key_valid_d = 1'b0;
            end
         end

         StLoad: begin
            in_ready = 1'b1;
            if (in_valid) begin
               idx_d = idx_q + IdxW'(1);
               if (idx_q == LastIdx) begin
                  state_d   = StSearch;
                  lfsr_d    = seed;
                  tap_idx_d = '0;
                  k_d       = FirstK;
               end
            end
         end

         StSearch: begin
            // A zero seed locks the LFSR at zero, so it can never be a valid key.
            if ((seed != 8'h00) && (adv_plain == SPACE)) begin
               lfsr_d = lfsr_adv;
               k_d    = k_q + IdxW'(1);
               if (k_q == LastPre) begin
                  state_d     = StSkip;
                  key_valid_d = 1'b1;
               end
            end else begin
               lfsr_d = seed;
               k_d    = FirstK;
               if (tap_idx_q == 3'd7) begin
                  state_d = StDone;
                  err_d   = 1'b1;
               end else begin
                  tap_idx_d = tap_idx_q + 3'd1;
               end
            end
         end

         StSkip: begin
            lfsr_d = lfsr_adv;
            if (adv_plain != SPACE) begin
               state_d = StEmit;
            end else if (k_q == LastIdx) begin
               state_d = StDone;
            end else begin
               k_d = k_q + IdxW'(1);
            end
         end

         StEmit: begin
            out_valid = 1'b1;
            out_data  = emit_plain;
            if (out_ready) begin
               out_count_d = out_count_q + 6'd1;
               if ((out_count_q == LastOut) || (k_q == LastIdx)) begin
                  state_d = StDone;
               end else begin
                  k_d    = k_q + IdxW'(1);
                  lfsr_d = lfsr_adv;
               end
            end
         end

         StDone: begin
            done = 1'b1;
            if (start) begin
               state_d     = StLoad;
               idx_d       = '0;
               err_d       = 1'b0;
               out_count_d = '0;
               key_valid_d = 1'b0;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         k_q         <= '0;
         tap_idx_q   <= '0;
         lfsr_q      <= '0;
         out_count_q <= '0;
         err_q       <= 1'b0;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         k_q         <= k_d;
         tap_idx_q   <= tap_idx_d;
         lfsr_q      <= lfsr_d;
         out_count_q <= out_count_d;
         err_q       <= err_d;
         key_valid_q <= key_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!init && frame_we) begin
         frame_q[idx_q] <= in_data;
      end
   end

   assign out_count = out_count_q;
   assign err       = err_q;

`ifdef LFSR_KEY_REPORT_EN
   assign key_tap_idx = key_valid_q ? tap_idx_q : 3'd0;
   assign key_seed    = key_valid_q ? seed : 8'h00;
`endif

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Directed bench for lfsr_decrypt_engine: frames are built by a small encrypt model and the
// recovered plaintext is compared against hand-written expectations.
module tb_lfsr_decrypt_engine;

   logic       clk = 1'b0;
   logic       init, start, in_valid, out_ready;
   logic [7:0] in_data, out_data;
   logic       in_ready, out_valid, done, err;
   logic [5:0] out_count;
`ifdef LFSR_KEY_REPORT_EN
   logic [2:0] key_tap_idx;
   logic [7:0] key_seed;
`endif

   int errors = 0;
   int checks = 0;

   logic [7:0] plain  [64];
   logic [7:0] cipher [64];
   logic [7:0] got    [$];
   int         cyc;
   bit         timeout;
   bit         load_ok;
   bit         ov_seen;
   int         stall_bad;
   logic [5:0] stall_cnt;
   int         bad;

   lfsr_decrypt_engine dut (
      .clk         (clk),
      .init        (init),
      .start       (start),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .out_count   (out_count),
      .done        (done),
`ifdef LFSR_KEY_REPORT_EN
      .err         (err),
      .key_tap_idx (key_tap_idx),
      .key_seed    (key_seed)
`else
      .err         (err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic set_plain(input int at, input string msg);
      for (int i = 0; i < 64; i++) plain[i] = 8'h20;
      for (int j = 0; j < msg.len(); j++) plain[at + j] = msg[j];
   endtask

   // Encrypt model: cipher[k] = plain[k] ^ state_k, state_0 = seed.
   task automatic encrypt(input logic [7:0] seed, input logic [7:0] tapv);
      logic [7:0] st;
      st = seed;
      for (int k = 0; k < 64; k++) begin
         cipher[k] = plain[k] ^ st;
         st = {st[6:0], ^(st & tapv)};
      end
   endtask

   task automatic send_frame(input bit do_start, input bit gaps, input bit stray);
      int i = 0;
      int n = 0;
      if (do_start) begin
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
      end
      while (i < 64 && n < 400) begin
         n++;
         start    = stray && (n == 20);
         in_valid = !(gaps && (n % 5 == 0));
         in_data  = cipher[i];
         if (in_valid && in_ready) i++;
         @(negedge clk);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      load_ok  = (i == 64);
   endtask

   task automatic drain(input int stall_at, input int stall_len);
      int left;
      logic [7:0] held_data;
      left = stall_len;
      held_data = 8'h00;
      got.delete();
      timeout = 0; stall_bad = 0; ov_seen = 0; cyc = 0; stall_cnt = 6'h3f;
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (done) break;
         if (cyc > 400) begin timeout = 1; break; end
         if (out_valid) begin
            ov_seen = 1;
            if (stall_len > 0 && got.size() == stall_at) begin
               if (left == stall_len) begin
                  held_data = out_data; stall_cnt = out_count;
               end else if (out_data !== held_data || out_count !== stall_cnt) begin
                  stall_bad++;
               end
            end
            if (stall_len > 0 && got.size() == stall_at && left > 0) begin
               out_ready = 1'b0; left--;
            end else begin
               out_ready = 1'b1; got.push_back(out_data);
            end
         end else begin
            out_ready = 1'b1;
         end
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      init = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      init = 1'b0; start = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
      checks++; if (out_count !== 6'd0) begin errors++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
`ifdef LFSR_KEY_REPORT_EN
      checks++; if (key_tap_idx !== 3'd0 || key_seed !== 8'h00) begin errors++; $display("FAIL reset_key: got %0d/%h expected 0/00", key_tap_idx, key_seed); end
`endif
      @(negedge clk);
      // start coincident with init must have been dropped
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL init_beats_start: in_ready got %b expected 0", in_ready); end
   endtask

   task automatic test_hi();
      set_plain(10, "Hi");
      encrypt(8'h01, 8'hb4);
      send_frame(1'b1, 1'b1, 1'b1);
      checks++; if (!load_ok) begin errors++; $display("FAIL hi_load: got %0d expected 1", load_ok); end
      drain(99, 0);
      bad = 0;
      for (int j = 2; j < got.size(); j++) if (got[j] !== 8'h20) bad++;
      checks++; if (timeout) begin errors++; $display("FAIL hi_timeout: got %0d expected 0", timeout); end
      checks++; if (got.size() != 41) begin errors++; $display("FAIL hi_bytes: got %0d expected 41", got.size()); end
      checks++; if (out_count !== 6'd41) begin errors++; $display("FAIL hi_count: got %0d expected 41", out_count); end
      checks++; if (got[0] !== 8'h48) begin errors++; $display("FAIL hi_byte0: got %h expected 48", got[0]); end
      checks++; if (got[1] !== 8'h69) begin errors++; $display("FAIL hi_byte1: got %h expected 69", got[1]); end
      checks++; if (bad != 0) begin errors++; $display("FAIL hi_trailing: got %0d non-space expected 0", bad); end
      checks++; if (err !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL hi_status: err/done got %b/%b expected 0/1", err, done); end
`ifdef LFSR_KEY_REPORT_EN
      checks++; if (key_tap_idx !== 3'd4 || key_seed !== 8'h01) begin errors++; $display("FAIL hi_key: got %0d/%h expected 4/01", key_tap_idx, key_seed); end
`endif
   endtask

   task automatic test_stall();
      set_plain(10, "Hi");
      encrypt(8'h01, 8'hb4);
      send_frame(1'b1, 1'b0, 1'b0);
      drain(1, 5);
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", stall_bad); end
      checks++; if (stall_cnt !== 6'd1) begin errors++; $display("FAIL stall_count: got %0d expected 1", stall_cnt); end
      checks++; if (got.size() != 41 || got[1] !== 8'h69) begin errors++; $display("FAIL stall_bytes: got %0d/%h expected 41/69", got.size(), got[1]); end
      checks++; if (out_count !== 6'd41) begin errors++; $display("FAIL stall_final_count: got %0d expected 41", out_count); end
   endtask

   task automatic test_bad_seed();
      set_plain(0, "");
      encrypt(8'h00, 8'hb4);
      send_frame(1'b1, 1'b0, 1'b0);
      drain(99, 0);
      checks++; if (timeout || cyc > 66) begin errors++; $display("FAIL badseed_latency: got %0d cycles expected <=66", cyc); end
      checks++; if (err !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL badseed_status: err/done got %b/%b expected 1/1", err, done); end
      checks++; if (out_count !== 6'd0) begin errors++; $display("FAIL badseed_count: got %0d expected 0", out_count); end
      checks++; if (ov_seen) begin errors++; $display("FAIL badseed_out_valid: got %0d expected 0", ov_seen); end
`ifdef LFSR_KEY_REPORT_EN
      checks++; if (key_tap_idx !== 3'd0 || key_seed !== 8'h00) begin errors++; $display("FAIL badseed_key: got %0d/%h expected 0/00", key_tap_idx, key_seed); end
`endif
   endtask

   task automatic test_restart_prog3();
      // From DONE: start must clear status and open the input port.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL restart_clear: done/err got %b/%b expected 0/0", done, err); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL restart_in_ready: got %b expected 1", in_ready); end
      set_plain(25, "f       A joke about LFSRs");
      encrypt(8'h01, 8'hfa);
      send_frame(1'b0, 1'b1, 1'b0);
      drain(99, 0);
      bad = 0;
      for (int j = 0; j < got.size(); j++) if (got[j] !== plain[25 + j]) bad++;
      checks++; if (got[0] !== 8'h66) begin errors++; $display("FAIL prog3_first: got %h expected 66", got[0]); end
      checks++; if (got[8] !== 8'h41) begin errors++; $display("FAIL prog3_byte8: got %h expected 41", got[8]); end
      checks++; if (out_count !== 6'd39 || got.size() != 39) begin errors++; $display("FAIL prog3_count: got %0d/%0d expected 39", out_count, got.size()); end
      checks++; if (bad != 0) begin errors++; $display("FAIL prog3_text: got %0d wrong bytes expected 0", bad); end
`ifdef LFSR_KEY_REPORT_EN
      checks++; if (key_tap_idx !== 3'd6 || key_seed !== 8'h01) begin errors++; $display("FAIL prog3_key: got %0d/%h expected 6/01", key_tap_idx, key_seed); end
`endif
   endtask

   task automatic test_init_search();
      set_plain(10, "Hi");
      encrypt(8'h01, 8'hb4);
      send_frame(1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      init = 1'b1;
      @(negedge clk);
      init = 1'b0;
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL init_status: done/err got %b/%b expected 0/0", done, err); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL init_idle: in_ready/out_valid got %b/%b expected 0/0", in_ready, out_valid); end
      checks++; if (out_count !== 6'd0) begin errors++; $display("FAIL init_count: got %0d expected 0", out_count); end
      send_frame(1'b1, 1'b0, 1'b0);
      drain(99, 0);
      checks++; if (got.size() != 41 || got[0] !== 8'h48 || got[1] !== 8'h69) begin errors++; $display("FAIL init_redo: got %0d/%h/%h expected 41/48/69", got.size(), got[0], got[1]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL init_redo_err: got %b expected 0", err); end
   endtask

   task automatic test_all_space();
      set_plain(0, "");
      encrypt(8'h01, 8'hb4);
      send_frame(1'b1, 1'b0, 1'b0);
      drain(99, 0);
      checks++; if (timeout || done !== 1'b1) begin errors++; $display("FAIL allspace_done: got %b expected 1", done); end
      checks++; if (out_count !== 6'd0) begin errors++; $display("FAIL allspace_count: got %0d expected 0", out_count); end
      checks++; if (ov_seen) begin errors++; $display("FAIL allspace_out_valid: got %0d expected 0", ov_seen); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL allspace_err: got %b expected 0", err); end
   endtask

   initial begin
      test_reset();
      test_hi();
      test_stall();
      test_bad_seed();
      test_restart_prog3();
      test_init_search();
      test_all_space();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
